// File: rtl/m68k_bus_responder.sv
// Windowed 68000 bus target: AS/UDS/LDS cycle -> mem_req/mem_ack handshake -> DTACKn (or BERRn on timeout).
// Latency: start edge -> mem_req next cycle, mem_ack edge -> dtack_n low next cycle (min 2 cycles); CPU stalls on DTACK, memory stalls via late ack.
module m68k_bus_responder #(
    parameter logic [23:0] C_BASE    = 24'h060000,
    parameter logic [23:0] C_SIZE    = 24'h002000,
    parameter int unsigned C_ADDR_W  = 12,
    parameter int unsigned C_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [23:1]         cpu_a,
    input  logic                cpu_as_n,
    input  logic                cpu_uds_n,
    input  logic                cpu_lds_n,
    input  logic                cpu_rw,
    input  logic [15:0]         cpu_dout,
    output logic [15:0]         cpu_din,
    output logic                dtack_n,
    output logic                berr_n,
    output logic                sel,
    output logic                mem_req,
    output logic                mem_we,
    output logic [C_ADDR_W-1:0] mem_addr,
    output logic [1:0]          mem_be,
    output logic [15:0]         mem_wdata,
    input  logic                mem_ack,
    input  logic [15:0]         mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK,
        ERR,
        WAITAS
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        abort;

    logic [23:0] byte_addr;
    logic [23:0] offset;
    logic        start;

    // Offset-based compare avoids overflow when the window ends at the top of the 16 MB space.
    assign byte_addr = {cpu_a, 1'b0};
    assign offset    = byte_addr - C_BASE;
    assign sel       = (byte_addr >= C_BASE) && (offset < C_SIZE);
    assign start     = !cpu_as_n && sel && (!cpu_uds_n || !cpu_lds_n);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            abort     <= 1'b0;
            dtack_n   <= 1'b1;
            berr_n    <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 2'b00;
            mem_wdata <= 16'd0;
            cpu_din   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr  <= offset[C_ADDR_W:1];
                        mem_be    <= {~cpu_uds_n, ~cpu_lds_n};
                        mem_we    <= ~cpu_rw;
                        mem_wdata <= cpu_dout;
                        mem_req   <= 1'b1;
                        cnt       <= 16'd0;
                        abort     <= 1'b0;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            cpu_din <= mem_rdata;
                        end
                        // A CPU that already dropped AS must not see a stray DTACK.
                        if (abort || cpu_as_n) begin
                            state <= WAITAS;
                        end else begin
                            dtack_n <= 1'b0;
                            state   <= ACK;
                        end
                    end else if (cnt == TMO_LAST) begin
                        mem_req <= 1'b0;
                        berr_n  <= 1'b0;
                        state   <= ERR;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (cpu_as_n) begin
                            abort <= 1'b1;
                        end
                    end
                end

                ACK: begin
                    if (cpu_as_n) begin
                        dtack_n <= 1'b1;
                        state   <= IDLE;
                    end
                end

                ERR: begin
                    if (cpu_as_n) begin
                        berr_n <= 1'b1;
                        state  <= WAITAS;
                    end
                end

                WAITAS: begin
                    if (cpu_as_n) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    dtack_n <= 1'b1;
                    berr_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: window decode, read/write handshakes, timeout, abort and reset.
module tb_m68k_bus_responder;

    logic        clk;
    logic        reset_n;
    logic [23:1] cpu_a;
    logic        cpu_as_n;
    logic        cpu_uds_n;
    logic        cpu_lds_n;
    logic        cpu_rw;
    logic [15:0] cpu_dout;
    logic [15:0] cpu_din;
    logic        dtack_n;
    logic        berr_n;
    logic        sel;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    m68k_bus_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_a     (cpu_a),
        .cpu_as_n  (cpu_as_n),
        .cpu_uds_n (cpu_uds_n),
        .cpu_lds_n (cpu_lds_n),
        .cpu_rw    (cpu_rw),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .dtack_n   (dtack_n),
        .berr_n    (berr_n),
        .sel       (sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [23:0] addr, input logic as_n, input logic uds_n,
                         input logic lds_n, input logic rw, input logic [15:0] dout);
        cpu_a     = addr[23:1];
        cpu_as_n  = as_n;
        cpu_uds_n = uds_n;
        cpu_lds_n = lds_n;
        cpu_rw    = rw;
        cpu_dout  = dout;
    endtask

    task automatic release_bus();
        cpu_as_n  = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        cpu_rw    = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL reset_dtack: got %b want 1", dtack_n); end
        checks++; if (berr_n !== 1'b1) begin errors++; $display("FAIL reset_berr: got %b want 1", berr_n); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
        checks++; if ({mem_we, mem_be, mem_addr} !== 15'd0) begin errors++; $display("FAIL reset_ctrl: we=%b be=%b addr=%h want 0", mem_we, mem_be, mem_addr); end
        checks++; if ({mem_wdata, cpu_din} !== 32'd0) begin errors++; $display("FAIL reset_data: wdata=%h din=%h want 0", mem_wdata, cpu_din); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_word_read();
        drive(24'h060010, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        #1;
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL rd_sel: got %b want 1", sel); end
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rd_req: got %b want 1", mem_req); end
        checks++; if (mem_addr !== 12'h008) begin errors++; $display("FAIL rd_addr: got %h want 008", mem_addr); end
        checks++; if (mem_be !== 2'b11 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_be_we: be=%b we=%b want 11/0", mem_be, mem_we); end
        step();
        step();
        checks++; if (mem_req !== 1'b1 || dtack_n !== 1'b1) begin errors++; $display("FAIL rd_wait: req=%b dtack=%b want 1/1", mem_req, dtack_n); end
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        checks++; if (dtack_n !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rd_dtack: dtack=%b req=%b want 0/0", dtack_n, mem_req); end
        checks++; if (cpu_din !== 16'hBEEF) begin errors++; $display("FAIL rd_din: got %h want BEEF", cpu_din); end
        step();
        step();
        checks++; if (dtack_n !== 1'b0 || cpu_din !== 16'hBEEF || mem_req !== 1'b0) begin errors++; $display("FAIL rd_hold: dtack=%b din=%h req=%b want 0/BEEF/0", dtack_n, cpu_din, mem_req); end
        release_bus();
        #3;
        checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL rd_hold_as: got %b want 0", dtack_n); end
        step();
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL rd_release: got %b want 1", dtack_n); end
        step();
    endtask

    task automatic test_byte_write();
        drive(24'h061FFF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h005A);
        step();
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wr_no_strobe: got %b want 0", mem_req); end
        cpu_lds_n = 1'b0;
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL wr_req: got %b want 1", mem_req); end
        checks++; if (mem_addr !== 12'hFFF) begin errors++; $display("FAIL wr_addr: got %h want FFF", mem_addr); end
        checks++; if (mem_be !== 2'b01 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_be_we: be=%b we=%b want 01/1", mem_be, mem_we); end
        checks++; if (mem_wdata !== 16'h005A) begin errors++; $display("FAIL wr_wdata: got %h want 005A", mem_wdata); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++; if (dtack_n !== 1'b0 || cpu_din !== 16'hBEEF) begin errors++; $display("FAIL wr_dtack: dtack=%b din=%h want 0/BEEF", dtack_n, cpu_din); end
        release_bus();
        step();
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL wr_release: got %b want 1", dtack_n); end
        step();
    endtask

    task automatic test_outside();
        logic [23:0] addrs [2];
        addrs[0] = 24'h062000;
        addrs[1] = 24'h05FFFE;
        for (int k = 0; k < 2; k++) begin
            int bad;
            bad = 0;
            drive(addrs[k], 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
            #1;
            checks++; if (sel !== 1'b0) begin errors++; $display("FAIL out_sel[%0d]: got %b want 0", k, sel); end
            for (int i = 0; i < 6; i++) begin
                step();
                if (mem_req !== 1'b0 || dtack_n !== 1'b1 || berr_n !== 1'b1) bad++;
            end
            checks++; if (bad !== 0) begin errors++; $display("FAIL out_quiet[%0d]: %0d bad cycles want 0", k, bad); end
            release_bus();
            step();
        end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        drive(24'h060000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to_req: got %b want 1", mem_req); end
        for (int i = 1; i < 64; i++) begin
            step();
            if (mem_req !== 1'b1 || berr_n !== 1'b1 || dtack_n !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL to_wait: %0d bad cycles want 0", bad); end
        step();
        checks++; if (mem_req !== 1'b0 || berr_n !== 1'b0) begin errors++; $display("FAIL to_berr: req=%b berr=%b want 0/0", mem_req, berr_n); end
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        step();
        mem_ack = 1'b0;
        checks++; if (berr_n !== 1'b0 || dtack_n !== 1'b1 || cpu_din !== 16'hBEEF) begin errors++; $display("FAIL to_late_ack: berr=%b dtack=%b din=%h want 0/1/BEEF", berr_n, dtack_n, cpu_din); end
        release_bus();
        step();
        checks++; if (berr_n !== 1'b1) begin errors++; $display("FAIL to_berr_release: got %b want 1", berr_n); end
        step();
        drive(24'h060002, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h001) begin errors++; $display("FAIL to_next_req: req=%b addr=%h want 1/001", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        checks++; if (dtack_n !== 1'b0 || cpu_din !== 16'h1234) begin errors++; $display("FAIL to_next_ack: dtack=%b din=%h want 0/1234", dtack_n, cpu_din); end
        release_bus();
        step();
        step();
    endtask

    task automatic test_abort();
        int bad;
        bad = 0;
        drive(24'h060004, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        step();
        step();
        release_bus();
        for (int i = 0; i < 2; i++) begin
            step();
            if (mem_req !== 1'b1 || dtack_n !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ab_hold_req: %0d bad cycles want 0", bad); end
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        step();
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0 || dtack_n !== 1'b1) begin errors++; $display("FAIL ab_ack: req=%b dtack=%b want 0/1", mem_req, dtack_n); end
        checks++; if (cpu_din !== 16'h7777) begin errors++; $display("FAIL ab_din: got %h want 7777", cpu_din); end
        step();
        checks++; if (dtack_n !== 1'b1 || berr_n !== 1'b1) begin errors++; $display("FAIL ab_idle: dtack=%b berr=%b want 1/1", dtack_n, berr_n); end
    endtask

    task automatic test_back_to_back();
        drive(24'h060008, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h004) begin errors++; $display("FAIL b2b_req1: req=%b addr=%h want 1/004", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        step();
        mem_ack = 1'b0;
        step();
        checks++; if (dtack_n !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_ack1: dtack=%b req=%b want 0/0", dtack_n, mem_req); end
        cpu_as_n = 1'b1;
        step();
        drive(24'h06000A, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        checks++; if (dtack_n !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_gap: dtack=%b req=%b want 1/0", dtack_n, mem_req); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h005) begin errors++; $display("FAIL b2b_req2: req=%b addr=%h want 1/005", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 16'hF00D;
        step();
        mem_ack = 1'b0;
        checks++; if (dtack_n !== 1'b0 || cpu_din !== 16'hF00D) begin errors++; $display("FAIL b2b_ack2: dtack=%b din=%h want 0/F00D", dtack_n, cpu_din); end
        release_bus();
        step();
        step();
    endtask

    task automatic test_reset_mid();
        drive(24'h060006, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req: got %b want 1", mem_req); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || dtack_n !== 1'b1 || berr_n !== 1'b1) begin errors++; $display("FAIL rst_mid_async: req=%b dtack=%b berr=%b want 0/1/1", mem_req, dtack_n, berr_n); end
        checks++; if (cpu_din !== 16'h0000 || mem_addr !== 12'h000) begin errors++; $display("FAIL rst_mid_regs: din=%h addr=%h want 0/0", cpu_din, mem_addr); end
        release_bus();
        reset_n = 1'b1;
        step();
        drive(24'h060008, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        step();
        mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        step();
        mem_ack = 1'b0;
        checks++; if (dtack_n !== 1'b0 || cpu_din !== 16'hA5A5 || mem_addr !== 12'h004) begin errors++; $display("FAIL rst_after: dtack=%b din=%h addr=%h want 0/A5A5/004", dtack_n, cpu_din, mem_addr); end
        release_bus();
        step();
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL rst_after_release: got %b want 1", dtack_n); end
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        cpu_a     = '0;
        cpu_dout  = 16'h0000;
        release_bus();
        test_reset();
        test_word_read();
        test_byte_write();
        test_outside();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
